// File: rtl/adder_bist_checker_pkg.sv
// Shared types and constants for the exhaustive 4-bit adder/subtractor BIST checker.
package adder_bist_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int A_W            = 4;
    localparam int B_W            = 4;
    localparam int K_W            = 1;
    localparam int VEC_W          = A_W + B_W + K_W;
    localparam int VEC_COUNT      = 512;
    localparam int SETTLE_DEFAULT = 4;

    localparam logic [VEC_W-1:0] LAST_INDEX = VEC_W'(VEC_COUNT - 1);

endpackage

// File: rtl/adder_bist_checker_golden.sv
// Reference 4-bit adder/subtractor: K=0 gives A+B, K=1 gives A+~B+1 (carry set iff A >= B).
module adder_sub_golden_4
    import adder_bist_checker_pkg::*;
(
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    input  logic [K_W-1:0] k,
    output logic [A_W-1:0] s,
    output logic           c
);

    logic [B_W-1:0] b_eff;
    logic [A_W:0]   result;

    assign b_eff  = k[0] ? ~b : b;
    assign result = {1'b0, a} + {1'b0, b_eff} + (A_W + 1)'(k);
    assign s      = result[A_W-1:0];
    assign c      = result[A_W];

endmodule

// File: rtl/adder_bist_checker.sv
// Sweeps all 512 {A,B,K} vectors into an external adder, compares each against a golden model.
module adder_bist_checker
    import adder_bist_checker_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEFAULT,
    parameter int ERR_W  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [A_W-1:0]   dut_a,
    output logic [B_W-1:0]   dut_b,
    output logic             dut_k,
    input  logic [A_W-1:0]   dut_s,
    input  logic             dut_c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] fail_vec,
    output logic             fail_valid
);

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_t           state;
    logic [VEC_W-1:0] index;
    logic [3:0]       settle_cnt;
    logic [A_W-1:0]   gold_s;
    logic             gold_c;
    logic             mismatch;

    // The index register is the stimulus: it is zero in IDLE and frozen in DONE.
    assign dut_a = index[VEC_W-1 -: A_W];
    assign dut_b = index[K_W +: B_W];
    assign dut_k = index[0];

    adder_sub_golden_4 u_golden (
        .a (dut_a),
        .b (dut_b),
        .k (dut_k),
        .s (gold_s),
        .c (gold_c)
    );

    assign mismatch = {dut_c, dut_s} != {gold_c, gold_s};

    // NOTE: all state uses non-blocking assignment so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            index      <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= APPLY;
                        index      <= '0;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_vec   <= '0;
                        fail_valid <= 1'b0;
                    end
                end
                APPLY: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + ERR_W'(1);
                        end
                        if (!fail_valid) begin
                            fail_vec   <= index;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (index == LAST_INDEX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Include this final vector's outcome, not yet visible in err_count.
                        pass  <= !mismatch && (err_count == '0);
                    end else begin
                        state      <= APPLY;
                        index      <= index + VEC_W'(1);
                        settle_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bist_checker.sv
// Directed bench: models the external adder with selectable faults and checks sweep results.
module tb_adder_bist_checker;

    logic       clk;
    logic       rst_n;
    logic       start;

    logic [3:0] a1, b1, s1;
    logic       k1, c1;
    logic       busy1, done1, pass1, fv_valid1;
    logic [9:0] err1;
    logic [8:0] fv1;

    logic [3:0] a2, b2, s2;
    logic       k2, c2;
    logic       busy2, done2, pass2, fv_valid2;
    logic [3:0] err2;
    logic [8:0] fv2;

    // 0 = healthy, 1 = S[0] stuck-at-0, 2 = carry inverted when subtracting
    logic [1:0] fault_mode;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t_start;

    adder_bist_checker #(.SETTLE(4), .ERR_W(10)) u_dut (
        .clk (clk), .rst_n (rst_n), .start (start),
        .dut_a (a1), .dut_b (b1), .dut_k (k1), .dut_s (s1), .dut_c (c1),
        .busy (busy1), .done (done1), .pass (pass1), .err_count (err1),
        .fail_vec (fv1), .fail_valid (fv_valid1)
    );

    adder_bist_checker #(.SETTLE(4), .ERR_W(4)) u_dut_sat (
        .clk (clk), .rst_n (rst_n), .start (start),
        .dut_a (a2), .dut_b (b2), .dut_k (k2), .dut_s (s2), .dut_c (c2),
        .busy (busy2), .done (done2), .pass (pass2), .err_count (err2),
        .fail_vec (fv2), .fail_valid (fv_valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Adder under test for the main checker, with injectable faults.
    always_comb begin
        logic [4:0] ideal;
        ideal = '0;
        if (k1) begin
            ideal[3:0] = a1 - b1;
            ideal[4]   = (a1 >= b1);
        end else begin
            ideal = {1'b0, a1} + {1'b0, b1};
        end
        s1 = ideal[3:0];
        c1 = ideal[4];
        if (fault_mode == 2'd1) s1[0] = 1'b0;
        if (fault_mode == 2'd2 && k1) c1 = ~ideal[4];
    end

    // Adder for the narrow-counter checker: every output bit inverted.
    always_comb begin
        logic [4:0] ideal;
        ideal = '0;
        if (k2) begin
            ideal[3:0] = a2 - b2;
            ideal[4]   = (a2 >= b2);
        end else begin
            ideal = {1'b0, a2} + {1'b0, b2};
        end
        s2 = ~ideal[3:0];
        c2 = ~ideal[4];
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        t_start = cyc;
    endtask

    task automatic wait_done(input string name, output int latency);
        int budget;
        budget = 4000;
        while (!done1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        latency = cyc - t_start;
        check({name, " done reached"}, 32'(done1), 32'd1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " busy"},       32'(busy1),      32'd0);
        check({tag, " done"},       32'(done1),      32'd0);
        check({tag, " pass"},       32'(pass1),      32'd0);
        check({tag, " err_count"},  32'(err1),       32'd0);
        check({tag, " fail_vec"},   32'(fv1),        32'd0);
        check({tag, " fail_valid"}, 32'(fv_valid1),  32'd0);
        check({tag, " dut_abk"},    32'({a1, b1, k1}), 32'd0);
        check({tag, " sat busy"},   32'(busy2),      32'd0);
        check({tag, " sat err"},    32'(err2),       32'd0);
    endtask

    typedef struct {
        logic [1:0] fault;
        int         exp_err;
        logic [8:0] exp_fv;
        logic       exp_valid;
        logic       exp_pass;
    } sweep_vec_t;

    sweep_vec_t vecs [3];

    initial begin
        int lat;
        string tag;

        vecs[0] = '{fault: 2'd0, exp_err: 0,   exp_fv: 9'h000, exp_valid: 1'b0, exp_pass: 1'b1};
        vecs[1] = '{fault: 2'd1, exp_err: 256, exp_fv: 9'h002, exp_valid: 1'b1, exp_pass: 1'b0};
        vecs[2] = '{fault: 2'd2, exp_err: 256, exp_fv: 9'h001, exp_valid: 1'b1, exp_pass: 1'b0};

        rst_n      = 1'b0;
        start      = 1'b0;
        fault_mode = 2'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_cleared("reset");

        for (int i = 0; i < 3; i++) begin
            tag = $sformatf("sweep%0d", i);
            fault_mode = vecs[i].fault;
            pulse_start();
            check({tag, " busy after start"}, 32'(busy1), 32'd1);
            check({tag, " first vector"},     32'({a1, b1, k1}), 32'd0);
            wait_done(tag, lat);
            check({tag, " latency"},    32'(lat),       32'd2560);
            check({tag, " busy"},       32'(busy1),     32'd0);
            check({tag, " err_count"},  32'(err1),      32'(vecs[i].exp_err));
            check({tag, " fail_vec"},   32'(fv1),       32'(vecs[i].exp_fv));
            check({tag, " fail_valid"}, 32'(fv_valid1), 32'(vecs[i].exp_valid));
            check({tag, " pass"},       32'(pass1),     32'(vecs[i].exp_pass));
            check({tag, " held abk"},   32'({a1, b1, k1}), 32'h1FF);
            check({tag, " sat err"},    32'(err2),      32'd15);
            check({tag, " sat fail_vec"}, 32'(fv2),     32'd0);
            check({tag, " sat pass"},   32'(pass2),     32'd0);
            check({tag, " sat done"},   32'(done2),     32'd1);
        end

        // Reset at cycle 100 of a faulty sweep, with start asserted during that reset.
        fault_mode = 2'd1;
        pulse_start();
        while (cyc - t_start < 100) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check_cleared("midreset");
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("start during reset ignored", 32'(busy1), 32'd0);

        pulse_start();
        wait_done("after reset", lat);
        check("after reset latency",   32'(lat),  32'd2560);
        check("after reset err_count", 32'(err1), 32'd256);
        check("after reset fail_vec",  32'(fv1),  32'h002);

        // A second start while busy must not restart or disturb the sweep.
        fault_mode = 2'd2;
        pulse_start();
        while (cyc - t_start < 50) @(negedge clk);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("busy after ignored start", 32'(busy1), 32'd1);
        wait_done("restart ignored", lat);
        check("restart ignored latency",   32'(lat),  32'd2560);
        check("restart ignored err_count", 32'(err1), 32'd256);
        check("restart ignored fail_vec",  32'(fv1),  32'h001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
